// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule sequencer: steps a single-round key expansion unit through all rounds
// and keeps every round key in a local register file with a combinational read port.
`timescale 1ns/1ps
module aes_key_sched_ctrl #(
    parameter int unsigned NUM_ROUNDS = 10,
    parameter int unsigned KEY_W      = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [KEY_W-1:0]      key_in,
    output logic                  busy,
    output logic                  done,
    output logic [KEY_W-1:0]      exp_key_in,
    output logic [31:0]           exp_rnd_constant,
    input  logic [KEY_W-1:0]      exp_key_out,
    input  logic [3:0]            rk_rd_idx,
    output logic [KEY_W-1:0]      rk_rd_data,
    output logic [NUM_ROUNDS:0]   rk_valid
);

    localparam int unsigned RND_W    = 4;
    localparam int unsigned RCON_W   = 8;
    localparam int unsigned NUM_KEYS = NUM_ROUNDS + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                busy_d;
    logic                done_d;
    logic                load_en;
    logic                cap_en;
    logic [RND_W-1:0]    round_q;
    logic [RCON_W-1:0]   rcon_q;
    logic [KEY_W-1:0]    rk_q [NUM_KEYS];

    function automatic logic [RCON_W-1:0] xtime(input logic [RCON_W-1:0] x);
        return {x[RCON_W-2:0], 1'b0} ^ (x[RCON_W-1] ? 8'h1B : 8'h00);
    endfunction

    // State register plus registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_SETTLE;
            S_SETTLE:  state_d = S_CAPTURE;
            S_CAPTURE: state_d = (round_q == RND_W'(NUM_ROUNDS)) ? S_DONE : S_SETTLE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output decode: handshake values are looked up from the upcoming state so they register in step
    always_comb begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        load_en = 1'b0;
        cap_en  = 1'b0;
        busy_d  = (state_d == S_SETTLE) || (state_d == S_CAPTURE);
        done_d  = (state_d == S_DONE);
        load_en = (state_q == S_IDLE) && start;
        cap_en  = (state_q == S_CAPTURE);
    end

    // Round counter, rcon and the expansion unit's key operand
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round_q    <= '0;
            rcon_q     <= RCON_W'(1);
            exp_key_in <= '0;
        end else if (load_en) begin
            round_q    <= RND_W'(1);
            rcon_q     <= RCON_W'(1);
            exp_key_in <= key_in;
        end else if (cap_en) begin
            exp_key_in <= exp_key_out;
            rcon_q     <= xtime(rcon_q);
            if (round_q != RND_W'(NUM_ROUNDS)) begin
                round_q <= round_q + RND_W'(1);
            end
        end
    end

    // Round-key storage and per-key valid flags; a new start invalidates all but key 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_KEYS; i++) begin
                rk_q[i] <= '0;
            end
            rk_valid <= '0;
        end else if (load_en) begin
            rk_q[0]  <= key_in;
            rk_valid <= NUM_KEYS'(1);
        end else if (cap_en) begin
            for (int unsigned i = 1; i < NUM_KEYS; i++) begin
                if (round_q == RND_W'(i)) begin
                    rk_q[i]     <= exp_key_out;
                    rk_valid[i] <= 1'b1;
                end
            end
        end
    end

    assign exp_rnd_constant = {24'h000000, rcon_q};

    // Read port; out-of-range indices return zero
    always_comb begin
        rk_rd_data = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (rk_rd_idx == RND_W'(i)) begin
                rk_rd_data = rk_q[i];
            end
        end
    end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural single-round expansion unit with a registered stage,
// plus a reference AES-128 key schedule built from GF(2^8) arithmetic.
`timescale 1ns/1ps
module tb_aes_key_sched_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic [127:0] exp_key_in;
    logic [31:0]  exp_rnd_constant;
    logic [127:0] exp_key_out;
    logic [3:0]   rk_rd_idx;
    logic [127:0] rk_rd_data;
    logic [10:0]  rk_valid;

    int vectors;
    int miscompares;

    logic [127:0] ref_rk [0:10];
    logic [127:0] mdl_rk [0:10];
    logic [7:0]   rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    aes_key_sched_ctrl dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .key_in           (key_in),
        .busy             (busy),
        .done             (done),
        .exp_key_in       (exp_key_in),
        .exp_rnd_constant (exp_rnd_constant),
        .exp_key_out      (exp_key_out),
        .rk_rd_idx        (rk_rd_idx),
        .rk_rd_data       (rk_rd_data),
        .rk_valid         (rk_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] expand_round(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Expansion unit model: output registered one edge after its inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_key_out <= '0;
        else        exp_key_out <= expand_round(exp_key_in, exp_rnd_constant[7:0]);
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic compute_ref(input logic [127:0] key);
        ref_rk[0] = key;
        for (int r = 1; r <= 10; r++) ref_rk[r] = expand_round(ref_rk[r-1], rcon_tab[r-1]);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full expansion starting from IDLE at a negedge; ends at the negedge after edge 21
    task automatic run_expand(input logic [127:0] key, input bit pulse);
        logic [10:0] vexp;
        compute_ref(key);
        key_in = key;
        start  = 1'b1;
        for (int k = 0; k <= 21; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 0)  start = pulse;
            if (k == 21) start = 1'b0;
            key_in = rand128();
            if (k % 2 == 0 && k <= 20) mdl_rk[k/2] = ref_rk[k/2];
            vexp = '0;
            for (int i = 0; i <= 10; i++) if (i <= k / 2) vexp[i] = 1'b1;
            if (k < 20) begin
                chk($sformatf("busy@%0d", k), 128'(busy), 128'(1));
                chk($sformatf("done@%0d", k), 128'(done), 128'(0));
                chk($sformatf("rcon@%0d", k), 128'(exp_rnd_constant), {120'h0, rcon_tab[k/2]});
                chk($sformatf("expkey@%0d", k), exp_key_in, ref_rk[k/2]);
                chk($sformatf("valid@%0d", k), 128'(rk_valid), 128'(vexp));
                rk_rd_idx = 4'((k + 1) / 2);
                #1;
                chk($sformatf("rdwr@%0d", k), rk_rd_data, mdl_rk[(k + 1) / 2]);
            end else if (k == 20) begin
                chk("done@20", 128'(done), 128'(1));
                chk("busy@20", 128'(busy), 128'(0));
                chk("valid@20", 128'(rk_valid), 128'(11'h7FF));
            end else begin
                chk("done@21", 128'(done), 128'(0));
                chk("busy@21", 128'(busy), 128'(0));
            end
        end
        if (pulse) begin
            @(posedge clk);
            @(negedge clk);
            chk("noqueue_busy", 128'(busy), 128'(0));
            chk("noqueue_valid", 128'(rk_valid), 128'(11'h7FF));
        end
        for (int i = 0; i <= 10; i++) begin
            rk_rd_idx = 4'(i);
            #1;
            chk($sformatf("rk%0d", i), rk_rd_data, ref_rk[i]);
        end
        for (int i = 11; i <= 15; i++) begin
            rk_rd_idx = 4'(i);
            #1;
            chk($sformatf("rk_oor%0d", i), rk_rd_data, 128'h0);
        end
    endtask

    initial begin
        logic [127:0] fips_key;
        logic [127:0] key;
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        key_in      = '0;
        rk_rd_idx   = '0;
        for (int i = 0; i <= 10; i++) mdl_rk[i] = '0;
        repeat (3) @(negedge clk);

        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_valid", 128'(rk_valid), 128'(0));
        chk("rst_expkey", exp_key_in, 128'h0);
        chk("rst_rcon", 128'(exp_rnd_constant), 128'(32'h1));
        chk("rst_rd", rk_rd_data, 128'h0);
        rst_n = 1'b1;
        @(negedge clk);

        fips_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        run_expand(fips_key, 1'b0);
        chk("fips_rk1", ref_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_rk10", ref_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Back-to-back start with start held high through busy and DONE
        run_expand(fips_key, 1'b1);

        run_expand(128'h0, 1'b0);
        chk("zero_rk1", ref_rk[1], 128'h62636363626363636263636362636363);
        chk("zero_rk10", ref_rk[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Abort during round 5
        key_in = rand128();
        start  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_done", 128'(done), 128'(0));
        chk("abort_valid", 128'(rk_valid), 128'(0));
        chk("abort_rcon", 128'(exp_rnd_constant), 128'(32'h1));
        for (int i = 0; i <= 10; i++) begin
            rk_rd_idx = 4'(i);
            #1;
            chk($sformatf("abort_rk%0d", i), rk_rd_data, 128'h0);
            mdl_rk[i] = '0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int n = 0; n < 4; n++) begin
            key = rand128();
            run_expand(key, n[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
